mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-port, fixed-latency unified memory between two requesters: the IF-stage instruction fetch port (read-only) and the MEM-stage data port (read/write). A 4-state FSM serialises accesses and returns registered read data with a one-cycle ready pulse. Pipeline stall logic drives if_stall/dm_stall from the req/ready pair. The arbiter sits between the pipeline and the memory macro, in place of separate instruction and data memories.

Parameters:
AW, 32, address width
DW, 32, data width
LAT, 2, memory read latency in cycles after the mem_en cycle; legal range is LAT >= 1
STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending; used only with the optional feature

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held with if_addr stable until if_ready
if_addr  in  AW  fetch address
if_rdata  out  DW  fetched word; valid in the if_ready cycle and held until the next fetch completes
if_ready  out  1  one-cycle completion pulse for fetch
dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata stable until dm_ready
dm_we  in  1  1 = write, 0 = read
dm_addr  in  AW  data address
dm_wdata  in  DW  store data
dm_rdata  out  DW  load data; valid in the dm_ready cycle and held until the next data read completes
dm_ready  out  1  one-cycle completion pulse for data port
mem_en  out  1  memory access strobe; exactly one cycle per access
mem_we  out  1  memory write enable; qualified by mem_en
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data; valid exactly LAT cycles after the mem_en cycle
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset = 0, async):
  - FSM goes to IDLE.
  - mem_en, mem_we, if_ready, dm_ready and busy go to 0.
  - mem_addr, mem_wdata, if_rdata and dm_rdata go to 0.
  - owner register, wait counter and starve counter clear.
  - An in-flight access is discarded; no ready pulse is issued.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If dm_req: owner = DM.
  - Else if if_req: owner = IF.
  - Else stay in IDLE.
  - On a grant, latch the owner's address, write data and we into registered mem_* outputs, then go to ISSUE.
  - Simultaneous requests: the data port wins, since it belongs to the older instruction (subject to the optional feature).
- ISSUE: one cycle.
  - mem_en = 1; mem_we = dm_we only when owner = DM (0 when owner = IF).
  - Load the wait counter with LAT, then go to WAIT.
- WAIT: exactly LAT cycles.
  - mem_en = 0; the counter decrements each cycle.
  - In the last WAIT cycle (counter = 1), mem_rdata is valid and is registered into the owner's rdata on that edge, for reads only.
  - Then go to RESP.
- RESP: one cycle.
  - Owner's ready = 1; the other ready stays 0. Next state is IDLE.
  - Writes also pulse dm_ready; dm_rdata is left unchanged on writes.
- Latency:
  - With the request first seen in IDLE at cycle t: mem_en high at t+1, ready high at t+LAT+2.
  - Maximum throughput is one access per LAT+3 cycles.
- Requesters must drop req on the edge that ends their ready cycle. A req still high in the following IDLE cycle is treated as a new request.
- A req deasserted mid-transaction is illegal. The arbiter still completes the access and pulses ready.
- No arbitration happens outside IDLE. Requests raised during ISSUE, WAIT or RESP wait for IDLE.
- Widths: the counter is $clog2(LAT+1) bits; no address arithmetic or alignment checks are performed.

Optional Feature:
- Macro: MEM_ARB_FAIR_EN.
- Defined:
  - A starve counter increments on each DM grant made while if_req = 1.
  - When the counter equals STARVE_MAX, the next IDLE arbitration with if_req = 1 grants IF even if dm_req = 1.
  - The counter clears on any IF grant, and on any arbitration where if_req = 0.
- Undefined: strict data-port priority; STARVE_MAX is ignored and no counter logic is generated.

Test Plan:
1. Reset, LAT=2, memory preloaded mem[0x40]=0xDEADBEEF. if_req=1, if_addr=0x40 at cycle 0 → mem_en=1, mem_we=0, mem_addr=0x40 at cycle 1; if_ready=1, if_rdata=0xDEADBEEF at cycle 4; busy low at cycle 5.
2. dm_req=1, dm_we=1, dm_addr=0x10, dm_wdata=0x12345678 → mem_en=1, mem_we=1, mem_wdata=0x12345678 at cycle 1; dm_ready at cycle 4; dm_rdata unchanged. Follow-up read of 0x10 returns 0x12345678.
3. if_req and dm_req asserted together at cycle 0 → DM granted first (dm_ready cycle 4). IF mem_en at cycle 6, if_ready at cycle 9. No cycle has both ready signals high.
4. LAT=1 boundary: single read → mem_en at cycle 1, ready at cycle 3; correct data captured.
5. Reset pulled low during WAIT of a data read → all outputs 0 immediately, no dm_ready. After release, a new IF request completes normally.
6. With MEM_ARB_FAIR_EN and STARVE_MAX=2: dm_req held continuously (re-raised after each ready) plus if_req held → grant order DM, DM, IF, DM. Without the macro: DM only, IF never granted while dm_req is high.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF fetches and MEM data accesses onto one fixed-latency memory.
// Define MEM_ARB_FAIR_EN to cap consecutive data grants while a fetch is waiting.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);
    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          grant_if;

`ifdef MEM_ARB_FAIR_EN
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_q, starve_d;
    // A fetch that has watched STARVE_MAX data grants go by wins the next arbitration.
    assign grant_if = if_req && (!dm_req || starve_q == SW'(STARVE_MAX));
    always_comb starve_d = (state_q != IDLE) ? starve_q :
                           (grant_if || !if_req) ? '0 : starve_q + 1'b1;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) starve_q <= '0;
        else        starve_q <= starve_d;
    end
`else
    assign grant_if = if_req && !dm_req;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        case (state_q)
            IDLE: if (grant_if || dm_req) begin
                state_d = ISSUE;
                owner_d = !grant_if;
                we_d    = !grant_if && dm_we;
                addr_d  = grant_if ? if_addr : dm_addr;
                wdata_d = grant_if ? '0 : dm_wdata;
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = CW'(LAT);
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = RESP;
                    if (!owner_q)   if_rdata_d = mem_rdata;
                    else if (!we_q) dm_rdata_d = mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign mem_en    = state_q == ISSUE;
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_ready  = state_q == RESP && !owner_q;
    assign dm_ready  = state_q == RESP && owner_q;
    assign busy      = state_q != IDLE;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with LAT=2 and LAT=1 instances.
// Each instance talks to a small behavioural memory with the matching read latency.
module tb_mem_port_arbiter;
    typedef struct {
        bit          dm;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   both_hi = 1'b0;
    exp_t sb_a[$];
    exp_t sb_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        a_if_req = 1'b0, a_dm_req = 1'b0, a_dm_we = 1'b0;
    logic [31:0] a_if_addr = '0, a_dm_addr = '0, a_dm_wdata = '0;
    logic [31:0] a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        a_if_ready, a_dm_ready, a_mem_en, a_mem_we, a_busy;

    logic        b_if_req = 1'b0, b_dm_req = 1'b0, b_dm_we = 1'b0;
    logic [31:0] b_if_addr = '0, b_dm_addr = '0, b_dm_wdata = '0;
    logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_if_ready, b_dm_ready, b_mem_en, b_mem_we, b_busy;

    mem_port_arbiter #(.AW(32), .DW(32), .LAT(2), .STARVE_MAX(2)) u_a (
        .clk(clk), .reset(reset),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ready(a_if_ready),
        .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
        .dm_rdata(a_dm_rdata), .dm_ready(a_dm_ready),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .LAT(1), .STARVE_MAX(2)) u_b (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
        .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
        .dm_rdata(b_dm_rdata), .dm_ready(b_dm_ready),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // Read data is garbage except exactly LAT cycles after a read strobe.
    logic [31:0] mem_a [logic [31:0]];
    logic [31:0] mem_b [logic [31:0]];
    logic [31:0] pipe_a [2];
    logic [31:0] pipe_b [1];
    always @(posedge clk) begin
        if (a_mem_en && a_mem_we) mem_a[a_mem_addr] = a_mem_wdata;
        pipe_a[0] <= (a_mem_en && !a_mem_we) ? (mem_a.exists(a_mem_addr) ? mem_a[a_mem_addr] : 32'h0) : 32'hBAD0BAD0;
        pipe_a[1] <= pipe_a[0];
        if (b_mem_en && b_mem_we) mem_b[b_mem_addr] = b_mem_wdata;
        pipe_b[0] <= (b_mem_en && !b_mem_we) ? (mem_b.exists(b_mem_addr) ? mem_b[b_mem_addr] : 32'h0) : 32'hBAD0BAD0;
    end
    assign a_mem_rdata = pipe_a[1];
    assign b_mem_rdata = pipe_b[0];

    task automatic wait_a(output int rc, output bit dm, output int en_c, output logic en_we,
                          output logic [31:0] en_addr, output logic [31:0] en_wd);
        rc = -1; dm = 1'b0; en_c = -1; en_we = 1'b0; en_addr = '0; en_wd = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (a_if_ready && a_dm_ready) both_hi = 1'b1;
            if (a_mem_en) begin
                en_c = cyc; en_we = a_mem_we; en_addr = a_mem_addr; en_wd = a_mem_wdata;
            end
            if (a_if_ready || a_dm_ready) begin
                rc = cyc;
                dm = a_dm_ready;
                if (a_dm_ready) a_dm_req = 1'b0;
                else a_if_req = 1'b0;
                return;
            end
        end
    endtask

    task automatic wait_b(output int rc, output bit dm, output int en_c);
        rc = -1; dm = 1'b0; en_c = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (b_mem_en) en_c = cyc;
            if (b_if_ready || b_dm_ready) begin
                rc = cyc;
                dm = b_dm_ready;
                if (b_dm_ready) b_dm_req = 1'b0;
                else b_if_req = 1'b0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({a_mem_en, a_mem_we, a_if_ready, a_dm_ready, a_busy} !== 5'b0 || a_mem_addr !== '0 ||
            a_mem_wdata !== '0 || a_if_rdata !== '0 || a_dm_rdata !== '0) begin
            n_err++;
            $display("FAIL reset_a: en=%b we=%b ifr=%b dmr=%b busy=%b addr=%h wd=%h ifd=%h dmd=%h, required all zero",
                     a_mem_en, a_mem_we, a_if_ready, a_dm_ready, a_busy, a_mem_addr, a_mem_wdata, a_if_rdata, a_dm_rdata);
        end
        n_cmp++;
        if ({b_mem_en, b_if_ready, b_dm_ready, b_busy} !== 4'b0 || b_dm_rdata !== '0) begin
            n_err++;
            $display("FAIL reset_b: en=%b ifr=%b dmr=%b busy=%b dmd=%h, required all zero",
                     b_mem_en, b_if_ready, b_dm_ready, b_busy, b_dm_rdata);
        end
        reset = 1'b1;
    endtask

    task automatic test_if_read();
        int t0, rc, en_c; bit dm; logic en_we; logic [31:0] en_addr, en_wd; exp_t e;
        @(negedge clk);
        t0 = cyc; a_if_addr = 32'h40; a_if_req = 1'b1;
        sb_a.push_back('{1'b0, 1'b1, 32'hDEADBEEF});
        wait_a(rc, dm, en_c, en_we, en_addr, en_wd);
        n_cmp++;
        if (en_c !== t0 + 1 || en_we !== 1'b0 || en_addr !== 32'h40) begin
            n_err++;
            $display("FAIL if_issue: en_cycle=%0d we=%b addr=%h, required en_cycle=%0d we=0 addr=00000040",
                     en_c - t0, en_we, en_addr, 1);
        end
        n_cmp++;
        if (rc !== t0 + 4) begin
            n_err++; $display("FAIL if_ready_cycle: got %0d, required 4", rc - t0);
        end
        e = sb_a.pop_front();
        n_cmp++;
        if (dm !== e.dm || a_if_rdata !== e.data) begin
            n_err++; $display("FAIL if_data: dm=%b rdata=%h, required dm=%b rdata=%h", dm, a_if_rdata, e.dm, e.data);
        end
        @(negedge clk);
        n_cmp++;
        if (a_busy !== 1'b0 || a_if_rdata !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL if_after: busy=%b rdata=%h, required busy=0 rdata=deadbeef", a_busy, a_if_rdata);
        end
    endtask

    task automatic test_write_readback();
        int t0, rc, en_c; bit dm; logic en_we; logic [31:0] en_addr, en_wd; exp_t e;
        @(negedge clk);
        t0 = cyc; a_dm_we = 1'b1; a_dm_addr = 32'h10; a_dm_wdata = 32'h12345678; a_dm_req = 1'b1;
        sb_a.push_back('{1'b1, 1'b0, 32'h0});
        wait_a(rc, dm, en_c, en_we, en_addr, en_wd);
        n_cmp++;
        if (en_c !== t0 + 1 || en_we !== 1'b1 || en_addr !== 32'h10 || en_wd !== 32'h12345678) begin
            n_err++;
            $display("FAIL wr_issue: en_cycle=%0d we=%b addr=%h wd=%h, required 1/1/00000010/12345678",
                     en_c - t0, en_we, en_addr, en_wd);
        end
        e = sb_a.pop_front();
        n_cmp++;
        if (rc !== t0 + 4 || dm !== e.dm || a_dm_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL wr_ready: cycle=%0d dm=%b rdata=%h, required cycle=4 dm=1 rdata=00000000", rc - t0, dm, a_dm_rdata);
        end
        @(negedge clk);
        t0 = cyc; a_dm_we = 1'b0; a_dm_req = 1'b1;
        sb_a.push_back('{1'b1, 1'b1, 32'h12345678});
        wait_a(rc, dm, en_c, en_we, en_addr, en_wd);
        e = sb_a.pop_front();
        n_cmp++;
        if (rc !== t0 + 4 || en_we !== 1'b0 || dm !== e.dm || a_dm_rdata !== e.data) begin
            n_err++;
            $display("FAIL rd_back: cycle=%0d we=%b dm=%b rdata=%h, required cycle=4 we=0 dm=1 rdata=%h",
                     rc - t0, en_we, dm, a_dm_rdata, e.data);
        end
    endtask

    task automatic test_simultaneous();
        int t0, rc, en_c; bit dm; logic en_we; logic [31:0] en_addr, en_wd; exp_t e;
        @(negedge clk);
        both_hi = 1'b0;
        t0 = cyc; a_if_addr = 32'h40; a_dm_we = 1'b0; a_dm_addr = 32'h10;
        a_if_req = 1'b1; a_dm_req = 1'b1;
        sb_a.push_back('{1'b1, 1'b1, 32'h12345678});
        sb_a.push_back('{1'b0, 1'b1, 32'hDEADBEEF});
        wait_a(rc, dm, en_c, en_we, en_addr, en_wd);
        e = sb_a.pop_front();
        n_cmp++;
        if (rc !== t0 + 4 || dm !== e.dm || a_dm_rdata !== e.data) begin
            n_err++;
            $display("FAIL sim_first: cycle=%0d dm=%b rdata=%h, required cycle=4 dm=1 rdata=%h", rc - t0, dm, a_dm_rdata, e.data);
        end
        wait_a(rc, dm, en_c, en_we, en_addr, en_wd);
        e = sb_a.pop_front();
        n_cmp++;
        if (en_c !== t0 + 6 || rc !== t0 + 9 || dm !== e.dm || a_if_rdata !== e.data) begin
            n_err++;
            $display("FAIL sim_second: en_cycle=%0d ready_cycle=%0d dm=%b rdata=%h, required 6/9/0/%h",
                     en_c - t0, rc - t0, dm, a_if_rdata, e.data);
        end
        n_cmp++;
        if (both_hi !== 1'b0) begin
            n_err++; $display("FAIL sim_both_ready: both readies seen high=%b, required 0", both_hi);
        end
    endtask

    task automatic test_lat1();
        int t0, rc, en_c; bit dm; exp_t e;
        mem_b[32'h80] = 32'hCAFEF00D;
        @(negedge clk);
        t0 = cyc; b_dm_we = 1'b0; b_dm_addr = 32'h80; b_dm_req = 1'b1;
        sb_b.push_back('{1'b1, 1'b1, 32'hCAFEF00D});
        wait_b(rc, dm, en_c);
        e = sb_b.pop_front();
        n_cmp++;
        if (en_c !== t0 + 1 || rc !== t0 + 3) begin
            n_err++; $display("FAIL lat1_timing: en_cycle=%0d ready_cycle=%0d, required 1/3", en_c - t0, rc - t0);
        end
        n_cmp++;
        if (dm !== e.dm || b_dm_rdata !== e.data) begin
            n_err++; $display("FAIL lat1_data: dm=%b rdata=%h, required dm=1 rdata=%h", dm, b_dm_rdata, e.data);
        end
    endtask

    task automatic test_reset_mid();
        int t0, rc, en_c; bit dm, seen; logic en_we; logic [31:0] en_addr, en_wd; exp_t e;
        @(negedge clk);
        t0 = cyc; a_dm_we = 1'b0; a_dm_addr = 32'h40; a_dm_req = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (a_busy !== 1'b1 || a_dm_ready !== 1'b0) begin
            n_err++; $display("FAIL mid_busy: busy=%b dmr=%b, required busy=1 dmr=0", a_busy, a_dm_ready);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({a_mem_en, a_mem_we, a_if_ready, a_dm_ready, a_busy} !== 5'b0 || a_mem_addr !== '0 ||
            a_mem_wdata !== '0 || a_if_rdata !== '0 || a_dm_rdata !== '0) begin
            n_err++;
            $display("FAIL mid_reset: en=%b we=%b ifr=%b dmr=%b busy=%b addr=%h wd=%h ifd=%h dmd=%h, required all zero",
                     a_mem_en, a_mem_we, a_if_ready, a_dm_ready, a_busy, a_mem_addr, a_mem_wdata, a_if_rdata, a_dm_rdata);
        end
        a_dm_req = 1'b0;
        seen = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a_dm_ready || a_if_ready || a_busy) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL mid_no_ready: activity after reset=%b, required 0", seen);
        end
        @(negedge clk);
        t0 = cyc; a_if_addr = 32'h40; a_if_req = 1'b1;
        sb_a.push_back('{1'b0, 1'b1, 32'hDEADBEEF});
        wait_a(rc, dm, en_c, en_we, en_addr, en_wd);
        e = sb_a.pop_front();
        n_cmp++;
        if (rc !== t0 + 4 || dm !== e.dm || a_if_rdata !== e.data) begin
            n_err++;
            $display("FAIL mid_recover: cycle=%0d dm=%b rdata=%h, required cycle=4 dm=0 rdata=%h", rc - t0, dm, a_if_rdata, e.data);
        end
    endtask

    task automatic test_fairness();
        int rc, en_c, n; bit dm; logic en_we; logic [31:0] en_addr, en_wd; exp_t e;
        bit exp_dm [5];
`ifdef MEM_ARB_FAIR_EN
        exp_dm = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        n = 4;
`else
        exp_dm = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        n = 5;
`endif
        for (int k = 0; k < n; k++)
            sb_a.push_back('{exp_dm[k], 1'b1, exp_dm[k] ? 32'h12345678 : 32'hDEADBEEF});
        both_hi = 1'b0;
        @(negedge clk);
        a_if_addr = 32'h40; a_dm_we = 1'b0; a_dm_addr = 32'h10;
        a_if_req = 1'b1; a_dm_req = 1'b1;
        for (int k = 0; k < n; k++) begin
            wait_a(rc, dm, en_c, en_we, en_addr, en_wd);
            e = sb_a.pop_front();
            n_cmp++;
            if (rc < 0 || dm !== e.dm || (dm ? a_dm_rdata : a_if_rdata) !== e.data) begin
                n_err++;
                $display("FAIL fair_grant%0d: dm=%b rdata=%h timeout=%0b, required dm=%b rdata=%h",
                         k, dm, dm ? a_dm_rdata : a_if_rdata, rc < 0, e.dm, e.data);
            end
            @(negedge clk);
            if (k < 3) a_dm_req = 1'b1;
        end
        n_cmp++;
        if (both_hi !== 1'b0 || a_if_req !== 1'b0 || a_dm_req !== 1'b0) begin
            n_err++;
            $display("FAIL fair_end: both=%b if_req=%b dm_req=%b, required all 0", both_hi, a_if_req, a_dm_req);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_a[32'h40] = 32'hDEADBEEF;
        test_reset();
        test_if_read();
        test_write_readback();
        test_simultaneous();
        test_lat1();
        test_reset_mid();
        test_fairness();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
